// File: rtl/root_power_loader.sv
// root_power_loader
// Streams twiddle words into the per-stage-row write ports of either the W or
// the WQ table of an NTT core. Each group of E/2 accepted words becomes one
// row beat. Beats fill N/(E/2) addresses of row 0, then of row 1, and so on
// up to row logE-1.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   start, sel_wq        : begin a load; sel_wq picks the table (0 = W, 1 = WQ)
//   in_data/valid/ready  : word stream. in_last marks the final word.
//                          Handshake: a word transfers on a rising edge where
//                          in_valid and in_ready are both 1. in_ready does not
//                          depend on in_valid. in_data and in_last are only
//                          looked at when a transfer happens.
//   ntt_input_W_*        : W table row write ports (waddr/wdata/wren per row)
//   ntt_input_WQ_*       : WQ table row write ports, same shapes
//   busy, done, err      : status. done is a one-cycle pulse. err is sticky
//                          until the next start.
//   dbg_state            : current FSM state, for observation only
module root_power_loader #(
  parameter int FSIZE = 64,
  parameter int E     = 8,
  parameter int logE  = 3,
  parameter int N     = 64,
  parameter int AW    = $clog2(N/(E/2))
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          sel_wq,
  input  logic [FSIZE-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  output logic [logE*AW-1:0]            ntt_input_W_waddr,
  output logic [logE*(E/2)*FSIZE-1:0]   ntt_input_W_wdata,
  output logic [logE*(E/2)-1:0]         ntt_input_W_wren,
  output logic [logE*AW-1:0]            ntt_input_WQ_waddr,
  output logic [logE*(E/2)*FSIZE-1:0]   ntt_input_WQ_wdata,
  output logic [logE*(E/2)-1:0]         ntt_input_WQ_wren,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    dbg_state
);

  localparam int L  = E / 2;
  localparam int R  = N / L;
  localparam int RW = L * FSIZE;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int SW = (logE > 1) ? $clog2(logE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_sel;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [LW-1:0]      r_lane;
  logic [AW-1:0]      r_addr;
  logic [SW-1:0]      r_stage;
  logic [RW-1:0]      r_pack;
  logic [logE*AW-1:0] r_w_waddr;
  logic [logE*AW-1:0] r_wq_waddr;
  logic [logE*RW-1:0] r_w_wdata;
  logic [logE*RW-1:0] r_wq_wdata;
  logic [logE*L-1:0]  r_w_wren;
  logic [logE*L-1:0]  r_wq_wren;

  logic               w_accept;
  logic               w_last_lane;
  logic               w_final;
  logic               w_beat;
  logic               w_end;
  logic               w_bad;
  logic [RW-1:0]      w_pack_next;
  logic [L-1:0]       w_mask;

  // r_in_ready is only ever 1 in LOAD. After the closing word it drops for
  // one wrap-up cycle, and that cycle is the one that shows the final beat.
  assign w_accept    = in_valid & r_in_ready;
  assign w_last_lane = (r_lane == LW'(L-1));
  assign w_final     = w_last_lane && (r_addr == AW'(R-1)) && (r_stage == SW'(logE-1));
  assign w_beat      = w_accept & (w_last_lane | in_last);
  assign w_end       = w_accept & (in_last | w_final);
  // Either in_last arrives early, or the final word arrives without it.
  assign w_bad       = w_accept & (in_last ^ w_final);

  // The beat carries the pack register with the word that is being accepted
  // merged in, so the row is written in the cycle right after that acceptance.
  always_comb begin
    w_pack_next = r_pack;
    w_mask      = '0;
    for (int i = 0; i < L; i++) begin
      if (LW'(i) == r_lane) w_pack_next[i*FSIZE +: FSIZE] = in_data;
      w_mask[i] = (LW'(i) <= r_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_lane     <= '0;
      r_addr     <= '0;
      r_stage    <= '0;
      r_pack     <= '0;
      r_w_waddr  <= '0;
      r_wq_waddr <= '0;
      r_w_wdata  <= '0;
      r_wq_wdata <= '0;
      r_w_wren   <= '0;
      r_wq_wren  <= '0;
    end else begin
      r_w_wren  <= '0;
      r_wq_wren <= '0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_sel      <= sel_wq;
            r_stage    <= '0;
            r_addr     <= '0;
            r_lane     <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (r_in_ready) begin
            if (w_accept) begin
              r_pack <= w_pack_next;
              if (w_beat) begin
                for (int r = 0; r < logE; r++) begin
                  if (r_stage == SW'(r)) begin
                    if (r_sel) begin
                      r_wq_waddr[r*AW +: AW] <= r_addr;
                      r_wq_wdata[r*RW +: RW] <= w_pack_next;
                      r_wq_wren[r*L +: L]    <= w_mask;
                    end else begin
                      r_w_waddr[r*AW +: AW]  <= r_addr;
                      r_w_wdata[r*RW +: RW]  <= w_pack_next;
                      r_w_wren[r*L +: L]     <= w_mask;
                    end
                  end
                end
              end
              if (w_end) begin
                r_in_ready <= 1'b0;
                r_err      <= r_err | w_bad;
              end else if (w_last_lane) begin
                r_lane <= '0;
                if (r_addr == AW'(R-1)) begin
                  r_addr  <= '0;
                  r_stage <= r_stage + SW'(1);
                end else begin
                  r_addr <= r_addr + AW'(1);
                end
              end else begin
                r_lane <= r_lane + LW'(1);
              end
            end
          end else begin
            // Wrap-up cycle: the last beat is on the ports right now.
            if (r_err) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready           = r_in_ready;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign dbg_state          = r_state;
  assign ntt_input_W_waddr  = r_w_waddr;
  assign ntt_input_W_wdata  = r_w_wdata;
  assign ntt_input_W_wren   = r_w_wren;
  assign ntt_input_WQ_waddr = r_wq_waddr;
  assign ntt_input_WQ_wdata = r_wq_wdata;
  assign ntt_input_WQ_wren  = r_wq_wren;

endmodule

// File: tb/tb_root_power_loader.sv
// Bench for root_power_loader. The drivers stream words into the DUT. For
// each word that completes a row beat, a reference model works out the
// expected beat from the word index alone: row = beat / 16, addr = beat % 16,
// lanes = the words of that beat. The driver pushes that expected beat into
// exp_q. A separate negedge monitor pops exp_q whenever any wren bit is high
// and compares what the DUT is writing.
module tb_root_power_loader;

  localparam int FSIZE = 64;
  localparam int E     = 8;
  localparam int LOGE  = 3;
  localparam int N     = 64;
  localparam int AW    = 4;
  localparam int L     = E / 2;
  localparam int R     = N / L;
  localparam int WORDS = LOGE * N;
  localparam int EW    = 1 + 2 + AW + L + L*FSIZE;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic                        sel_wq;
  logic [FSIZE-1:0]            in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic [LOGE*AW-1:0]          w_waddr;
  logic [LOGE*L*FSIZE-1:0]     w_wdata;
  logic [LOGE*L-1:0]           w_wren;
  logic [LOGE*AW-1:0]          wq_waddr;
  logic [LOGE*L*FSIZE-1:0]     wq_wdata;
  logic [LOGE*L-1:0]           wq_wren;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [1:0]                  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  root_power_loader #(.FSIZE(FSIZE), .E(E), .logE(LOGE), .N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_wq(sel_wq),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ntt_input_W_waddr(w_waddr), .ntt_input_W_wdata(w_wdata), .ntt_input_W_wren(w_wren),
    .ntt_input_WQ_waddr(wq_waddr), .ntt_input_WQ_wdata(wq_wdata), .ntt_input_WQ_wren(wq_wren),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_beat(input logic tbl, input logic [1:0] row,
                                              input logic [AW-1:0] addr, input logic [L-1:0] mask,
                                              input logic [L*FSIZE-1:0] data);
    logic [L*FSIZE-1:0] d;
    d = data;
    for (int i = 0; i < L; i++)
      if (!mask[i]) d[i*FSIZE +: FSIZE] = '0;
    return {tbl, row, addr, mask, d};
  endfunction

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_wren", {w_wren, wq_wren}, 0);
    chk("rst_waddr", {w_waddr, wq_waddr}, 0);
    chk("rst_wdata", {|w_wdata, |wq_wdata}, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    logic [EW-1:0]       act;
    logic                tsel;
    int                  row;
    int                  idx;
    logic [LOGE*L-1:0]   wr;
    logic [2*LOGE*L-1:0] stray;
    if ((|w_wren) || (|wq_wren)) begin
      tsel = ~(|w_wren);
      wr   = tsel ? wq_wren : w_wren;
      row  = 0;
      for (int r = LOGE-1; r >= 0; r--)
        if (|wr[r*L +: L]) row = r;
      idx   = (tsel ? LOGE : 0) + row;
      stray = {wq_wren, w_wren};
      stray[idx*L +: L] = '0;
      chk("stray_wren", stray, 0);
      act = pack_beat(tsel, 2'(row),
                      tsel ? wq_waddr[row*AW +: AW] : w_waddr[row*AW +: AW],
                      wr[row*L +: L],
                      tsel ? wq_wdata[row*L*FSIZE +: L*FSIZE] : w_wdata[row*L*FSIZE +: L*FSIZE]);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", act, 0);
      end else begin
        chk("beat", act, exp_q.pop_front());
        chk("beat_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // gap_mode: 0 continuous, 1 valid every other cycle, 2 random gaps.
  // last_at: index of the word carrying in_last (-1 = never).
  // abort_after: reset after this many accepted words (-1 = never).
  // restart_at: pulse start (other table) in a gap before this word (-1 = never).
  task automatic run_load(input logic tbl, input int nwords, input int last_at,
                          input int gap_mode, input int rand_data,
                          input int abort_after, input int restart_at);
    logic [FSIZE-1:0]   mbuf [L];
    logic [L*FSIZE-1:0] bd;
    logic [FSIZE-1:0]   d;
    logic               rdy;
    logic               acc;
    logic               good;
    int                 gap;
    int                 lane;
    int                 bi;
    for (int i = 0; i < L; i++) mbuf[i] = '0;
    @(posedge clk); #1;
    start = 1'b1; sel_wq = tbl;
    @(posedge clk); #1;
    start = 1'b0; sel_wq = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("load_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_err_clear", err, 0);
    @(posedge clk); #1;
    for (int k = 0; k < nwords; k++) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (k == restart_at && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (k == restart_at && g == 0) begin
          start = 1'b1; sel_wq = ~tbl;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      d = rand_data ? {$urandom, $urandom} : FSIZE'(k);
      in_valid = 1'b1; in_data = d; in_last = (k == last_at);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk); rdy = in_ready;
        @(posedge clk); acc = rdy;
      end
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (!acc) begin
        chk("accept_timeout", acc, 1);
        return;
      end
      lane = k % L;
      mbuf[lane] = d;
      if (lane == L-1 || k == last_at) begin
        bi = k / L;
        for (int i = 0; i < L; i++) bd[i*FSIZE +: FSIZE] = mbuf[i];
        exp_q.push_back(pack_beat(tbl, 2'(bi / R), AW'(bi % R), L'((1 << (lane + 1)) - 1), bd));
        exp_cyc_q.push_back(cyc);
      end
      if (k + 1 == abort_after) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        return;
      end
      if (k == last_at) break;
    end
    good = (last_at == WORDS-1) && (nwords == WORDS);
    @(negedge clk);
    chk("end_ready", in_ready, 0);
    chk("end_busy", busy, 1);
    chk("end_done_early", done, 0);
    chk("end_err", err, !good);
    @(negedge clk);
    chk("done_pulse", done, good);
    chk("done_busy", busy, good);
    chk("done_err", err, !good);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_state", dbg_state, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; sel_wq = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    run_load(1'b0, WORDS, WORDS-1, 0, 0, -1, -1);   // full W load, words 0..191
    run_load(1'b1, WORDS, WORDS-1, 1, 0, -1, -1);   // WQ load, valid every other cycle
    run_load(1'b0, 10, 9, 0, 0, -1, -1);            // early in_last on word 9
    begin
      int n;
      n = int'($urandom_range(1, 150));
      run_load(1'($urandom_range(0, 1)), n, n-1, 2, 1, -1, -1);  // random early in_last
    end
    run_load(1'b0, WORDS, -1, 2, 1, -1, -1);        // missing in_last
    run_load(1'b0, WORDS, WORDS-1, 2, 1, -1, 21);   // start pulsed mid-load
    run_load(1'b0, WORDS, -1, 0, 0, 50, -1);        // reset after 50 words
    run_load(1'b1, WORDS, WORDS-1, 2, 1, -1, -1);   // clean load after reset

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/root_power_loader.md
ROOT_POWER_LOADER -- requirements
Module: root_power_loader

Interface
- REQ-001: Parameters, one per line: name, default, meaning.
  - FSIZE, 64: word width.
  - E, 8: butterfly width; E/2 lanes per row.
  - logE, 3: number of stage rows.
  - N, 64: polynomial degree.
  - AW, $clog2(N/(E/2)): row address width.
- REQ-002: One clock; reset is synchronous and active-high.
- REQ-003: Ports, one per line: name, direction, width, meaning.
  - clk, in, 1: clock.
  - rst, in, 1: synchronous active-high reset.
  - start, in, 1: begin a table load.
  - sel_wq, in, 1: target; 0 = W table, 1 = WQ table; sampled on start.
  - in_data, in, FSIZE: twiddle word stream.
  - in_valid, in, 1: stream valid.
  - in_ready, out, 1: stream ready.
  - in_last, in, 1: marks the final word of the table.
  - ntt_input_W_waddr, out, logE x AW: W write address per stage row.
  - ntt_input_W_wdata, out, logE x E/2 x FSIZE: W write data per row and lane.
  - ntt_input_W_wren, out, logE x E/2: W lane write enables.
  - ntt_input_WQ_waddr, ntt_input_WQ_wdata, ntt_input_WQ_wren, out: same shapes as the W ports, for the WQ table.
  - busy, out, 1: load in progress.
  - done, out, 1: one-cycle pulse on successful completion.
  - err, out, 1: sticky; set on a framing error.

Function
- REQ-004: States are IDLE, LOAD and DONE; reset enters IDLE.
- REQ-005: IDLE -> LOAD on start=1; sel_wq is latched, stage counter, address counter and lane counter are zeroed, and err is cleared.
- REQ-006: start is ignored outside IDLE.
- REQ-007: in_ready=1 only in LOAD; a word is accepted when in_valid and in_ready are both 1.
- REQ-008: Accepted words fill lanes 0..E/2-1 of a pack register in arrival order.
- REQ-009: In the cycle after the word for lane E/2-1 is accepted, the row beat is written on the selected table:
  - row = stage counter;
  - waddr[row] = address counter;
  - wdata[row] = pack register;
  - wren[row] = all ones.
- REQ-010: On every beat, all other rows and the unselected table have wren=0.
- REQ-011: wren is a single-cycle pulse.
- REQ-012: waddr and wdata hold their last value when wren=0.
- REQ-013: The address counter increments after each beat and wraps from N/(E/2)-1 to 0; the wrap increments the stage counter.
- REQ-014: The expected table size is logE*N/(E/2) beats, which is logE*N words.
- REQ-015: When in_last is accepted on the final word of the final beat, the state goes LOAD -> DONE.
- REQ-016: DONE lasts one cycle with done=1, then returns to IDLE.
- REQ-017: Framing errors:
  - in_last accepted on any other word: err=1, the partial pack is still written with wren set only for the filled lanes, then the state returns to IDLE with no done.
  - The final word arriving without in_last: err=1, the final beat is written, then the state returns to IDLE with no done.
- REQ-018: busy=1 in LOAD and DONE.
- REQ-019: Acceptance stalls cleanly when in_valid=0; the counters and pack register hold.

Reset
- REQ-020: With rst=1 at a clock edge, the next state is:
  - state IDLE;
  - in_ready, busy, done and err all 0;
  - every wren bit 0;
  - all waddr and wdata 0;
  - all counters 0.
- REQ-021: Reset mid-LOAD abandons the load with no further wren, and a partial pack is discarded.

Verification
- REQ-022: Full W load, N=64, E=8, logE=3:
  - Stimulus: start with sel_wq=0, then 192 words 0..191 streamed continuously, in_last on word 191.
  - Response: 48 beats; beat k has row k/16, waddr k%16, lanes = 4k..4k+3.
  - done pulses 2 cycles after word 191 is accepted; all WQ wren stay 0.
- REQ-023: WQ load with in_valid toggling every other cycle:
  - Response: same data mapping as REQ-022, only on the WQ ports.
  - No wren pulse occurs in a cycle that does not follow the acceptance of a fourth lane.
- REQ-024: Early in_last on word 9 of a W load:
  - Response: beats at addr 0 and 1, then a partial beat at addr 2 with wren=4'b0011 and lanes 8,9.
  - err=1, no done, IDLE next.
- REQ-025: Missing in_last on word 191:
  - Response: 48 beats written, err=1, done stays 0.
- REQ-026: start pulsed again mid-load:
  - Response: ignored; counters and table selection are unchanged.
- REQ-027: rst asserted after 50 accepted words:
  - Response: outputs are at reset values the next cycle, no beat for words 48..49 appears, and a following load starts at row 0, addr 0.
